// File: rtl/mips_muldiv_pkg.sv
// Shared funct codes and FSM state type for the MIPS multiply/divide unit.
package mips_muldiv_pkg;

   localparam logic [5:0] FN_MFHI  = 6'd16;
   localparam logic [5:0] FN_MTHI  = 6'd17;
   localparam logic [5:0] FN_MFLO  = 6'd18;
   localparam logic [5:0] FN_MTLO  = 6'd19;
   localparam logic [5:0] FN_MULT  = 6'd24;
   localparam logic [5:0] FN_MULTU = 6'd25;
   localparam logic [5:0] FN_DIV   = 6'd26;
   localparam logic [5:0] FN_DIVU  = 6'd27;

   typedef enum logic [1:0] {
      MDU_IDLE,
      MDU_RUN,
      MDU_FIX
   } mdu_state_e;

endpackage

// File: rtl/mips_muldiv.sv
// Iterative one-bit-per-cycle multiply/divide unit that owns HI/LO.
// Multiply and divide share a single 2*WIDTH working register and counter.
module mips_muldiv #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);
   import mips_muldiv_pkg::*;

   localparam int unsigned W2 = 2 * WIDTH;
   localparam int unsigned CW = $clog2(WIDTH + 1);

   mdu_state_e       state_q;
   logic [CW-1:0]    cnt_q;
   logic [W2-1:0]    work_q;
   logic [WIDTH-1:0] opnd_q;
   logic [WIDTH-1:0] a_q;
   logic             is_div_q;
   logic             neg_q;
   logic             rneg_q;
   logic             dbz_q;
   logic [WIDTH-1:0] hi_q;
   logic [WIDTH-1:0] lo_q;
   logic             done_q;
   logic             dbz_out_q;

   logic             is_mul_c;
   logic             is_div_c;
   logic             is_signed_c;
   logic [WIDTH-1:0] a_mag_c;
   logic [WIDTH-1:0] b_mag_c;
   logic [WIDTH:0]   mul_sum_c;
   logic [WIDTH:0]   div_diff_c;
   logic [W2-1:0]    work_d;
   logic [W2-1:0]    prod_fix_c;
   logic [WIDTH-1:0] quo_fix_c;
   logic [WIDTH-1:0] rem_fix_c;

   // Decode, operand magnitudes, per-cycle iteration step and sign fix-up.
   always_comb begin
      is_mul_c    = (funct == FN_MULT) || (funct == FN_MULTU);
      is_div_c    = (funct == FN_DIV)  || (funct == FN_DIVU);
      is_signed_c = (funct == FN_MULT) || (funct == FN_DIV);
      a_mag_c     = (is_signed_c && a[WIDTH-1]) ? -a : a;
      b_mag_c     = (is_signed_c && b[WIDTH-1]) ? -b : b;

      mul_sum_c  = {1'b0, work_q[W2-1:WIDTH]} + {1'b0, opnd_q};
      div_diff_c = work_q[W2-1:WIDTH-1] - {1'b0, opnd_q};

      work_d = work_q;
      if (is_div_q) begin
         // A clear top bit means the shifted remainder covered the divisor.
         if (!div_diff_c[WIDTH]) begin
            work_d = {div_diff_c[WIDTH-1:0], work_q[WIDTH-2:0], 1'b1};
         end else begin
            work_d = {work_q[W2-2:0], 1'b0};
         end
      end else if (work_q[0]) begin
         work_d = {mul_sum_c, work_q[WIDTH-1:1]};
      end else begin
         work_d = {1'b0, work_q[W2-1:1]};
      end

      prod_fix_c = neg_q  ? -work_q : work_q;
      quo_fix_c  = neg_q  ? -work_q[WIDTH-1:0]  : work_q[WIDTH-1:0];
      rem_fix_c  = rneg_q ? -work_q[W2-1:WIDTH] : work_q[W2-1:WIDTH];
   end

   // Control FSM, working register and HI/LO.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= MDU_IDLE;
         cnt_q     <= '0;
         work_q    <= '0;
         opnd_q    <= '0;
         a_q       <= '0;
         is_div_q  <= 1'b0;
         neg_q     <= 1'b0;
         rneg_q    <= 1'b0;
         dbz_q     <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
      end else begin
         done_q    <= 1'b0;
         dbz_out_q <= 1'b0;
         case (state_q)
            MDU_IDLE: begin
               if (start) begin
                  if (is_mul_c || is_div_c) begin
                     // Multiplier (or dividend) sits in the low half of work.
                     work_q   <= {{WIDTH{1'b0}}, (is_div_c ? a_mag_c : b_mag_c)};
                     opnd_q   <= is_div_c ? b_mag_c : a_mag_c;
                     a_q      <= a;
                     is_div_q <= is_div_c;
                     neg_q    <= is_signed_c && (a[WIDTH-1] ^ b[WIDTH-1]);
                     rneg_q   <= is_signed_c && a[WIDTH-1];
                     dbz_q    <= is_div_c && (b == '0);
                     cnt_q    <= CW'(WIDTH);
                     state_q  <= MDU_RUN;
                  end else if (funct == FN_MTHI) begin
                     hi_q <= a;
                  end else if (funct == FN_MTLO) begin
                     lo_q <= a;
                  end
               end
            end
            MDU_RUN: begin
               work_q <= work_d;
               cnt_q  <= cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_q <= MDU_FIX;
               end
            end
            MDU_FIX: begin
               if (!is_div_q) begin
                  hi_q <= prod_fix_c[W2-1:WIDTH];
                  lo_q <= prod_fix_c[WIDTH-1:0];
               end else if (dbz_q) begin
                  hi_q <= a_q;
                  lo_q <= '1;
               end else begin
                  hi_q <= rem_fix_c;
                  lo_q <= quo_fix_c;
               end
               done_q    <= 1'b1;
               dbz_out_q <= is_div_q && dbz_q;
               state_q   <= MDU_IDLE;
            end
            default: state_q <= MDU_IDLE;
         endcase
      end
   end

   assign busy        = (state_q != MDU_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_out_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv.sv
// Directed self-checking bench for mips_muldiv at WIDTH = 32.
module tb_mips_muldiv;
   import mips_muldiv_pkg::*;

   logic        clk;
   logic        rst;
   logic        start;
   logic [5:0]  funct;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic        done;
   logic        div_by_zero;
   logic [31:0] hi;
   logic [31:0] lo;

   int n_checks = 0;
   int n_fail   = 0;

   mips_muldiv #(.WIDTH(32)) dut (
      .clk         (clk),
      .rst         (rst),
      .start       (start),
      .funct       (funct),
      .a           (a),
      .b           (b),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Present a start for exactly one edge; returns just after that edge.
   task automatic issue(input logic [5:0] f, input logic [31:0] av, input logic [31:0] bv);
      start = 1'b1;
      funct = f;
      a     = av;
      b     = bv;
      step(1);
      start = 1'b0;
   endtask

   // Count edges until done is seen, bounded so a stuck design still ends.
   task automatic wait_done(output int lat, output int bcnt);
      lat  = 0;
      bcnt = 0;
      while (done !== 1'b1 && lat < 40) begin
         if (busy === 1'b1) bcnt++;
         step(1);
         lat++;
      end
   endtask

   int lat;
   int bcnt;
   int seen;

   initial begin
      rst   = 1'b1;
      start = 1'b0;
      funct = 6'd0;
      a     = '0;
      b     = '0;
      step(2);
      rst = 1'b0;

      check("rst_hi",   hi, 32'h0);
      check("rst_lo",   lo, 32'h0);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_dbz",  32'(div_by_zero), 32'h0);

      // MULTU max * max, with latency and busy-length checks
      issue(FN_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      check("multu_lat",  32'(lat), 32'd33);
      check("multu_busy", 32'(bcnt), 32'd33);
      check("multu_hi",   hi, 32'hFFFF_FFFE);
      check("multu_lo",   lo, 32'h0000_0001);
      check("multu_dbz",  32'(div_by_zero), 32'h0);
      step(1);
      check("done_pulse", 32'(done), 32'h0);

      // MULT -3 * 7, HI/LO must hold the old product mid-run
      issue(FN_MULT, 32'hFFFF_FFFD, 32'd7);
      step(5);
      check("hold_hi", hi, 32'hFFFF_FFFE);
      check("hold_lo", lo, 32'h0000_0001);
      wait_done(lat, bcnt);
      check("mult_lat", 32'(lat + 5), 32'd33);
      check("mult_hi",  hi, 32'hFFFF_FFFF);
      check("mult_lo",  lo, 32'hFFFF_FFEB);

      issue(FN_MULT, 32'h8000_0000, 32'h8000_0000);
      wait_done(lat, bcnt);
      check("multmn_hi", hi, 32'h4000_0000);
      check("multmn_lo", lo, 32'h0000_0000);

      // Divides
      issue(FN_DIV, 32'hFFFF_FFF9, 32'd2);
      wait_done(lat, bcnt);
      check("div_lo",  lo, 32'hFFFF_FFFD);
      check("div_hi",  hi, 32'hFFFF_FFFF);
      check("div_dbz", 32'(div_by_zero), 32'h0);

      issue(FN_DIVU, 32'd7, 32'd2);
      wait_done(lat, bcnt);
      check("divu_lo", lo, 32'd3);
      check("divu_hi", hi, 32'd1);

      issue(FN_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      wait_done(lat, bcnt);
      check("divovf_lo", lo, 32'h8000_0000);
      check("divovf_hi", hi, 32'h0);

      issue(FN_DIV, 32'd5, 32'd0);
      wait_done(lat, bcnt);
      check("dbz_lat",  32'(lat), 32'd33);
      check("dbz_hi",   hi, 32'd5);
      check("dbz_lo",   lo, 32'hFFFF_FFFF);
      check("dbz_flag", 32'(div_by_zero), 32'h1);
      step(1);
      check("dbz_clr",  32'(div_by_zero), 32'h0);

      // MTHI / MTLO / MFHI
      issue(FN_MTHI, 32'h0000_1234, 32'h0);
      check("mthi_hi",   hi, 32'h0000_1234);
      check("mthi_busy", 32'(busy), 32'h0);
      check("mthi_done", 32'(done), 32'h0);
      issue(FN_MTLO, 32'h0000_ABCD, 32'h0);
      check("mtlo_lo",   lo, 32'h0000_ABCD);
      check("mtlo_hi",   hi, 32'h0000_1234);
      check("mtlo_done", 32'(done), 32'h0);
      issue(FN_MFHI, 32'h0000_DEAD, 32'h0);
      check("mfhi_busy", 32'(busy), 32'h0);
      check("mfhi_hi",   hi, 32'h0000_1234);
      check("mfhi_lo",   lo, 32'h0000_ABCD);

      // Start while busy is dropped
      issue(FN_MULTU, 32'd6, 32'd7);
      step(3);
      issue(FN_MULTU, 32'd100, 32'd100);
      wait_done(lat, bcnt);
      check("busy_lat", 32'(lat + 4), 32'd33);
      check("busy_lo",  lo, 32'd42);
      check("busy_hi",  hi, 32'd0);

      // Back-to-back start in the done cycle
      issue(FN_DIVU, 32'd100, 32'd7);
      check("b2b_busy", 32'(busy), 32'h1);
      check("b2b_done", 32'(done), 32'h0);
      wait_done(lat, bcnt);
      check("b2b_lat", 32'(lat), 32'd33);
      check("b2b_lo",  lo, 32'd14);
      check("b2b_hi",  hi, 32'd2);

      // Reset in RUN cycle 10, with a competing MTHI start
      issue(FN_MULTU, 32'd3, 32'd5);
      step(9);
      rst   = 1'b1;
      start = 1'b1;
      funct = FN_MTHI;
      a     = 32'h0000_0077;
      step(1);
      rst   = 1'b0;
      start = 1'b0;
      check("mrst_busy", 32'(busy), 32'h0);
      check("mrst_hi",   hi, 32'h0);
      check("mrst_lo",   lo, 32'h0);
      check("mrst_done", 32'(done), 32'h0);
      seen = 0;
      repeat (40) begin
         if (done === 1'b1 || busy === 1'b1) seen++;
         step(1);
      end
      check("mrst_quiet", 32'(seen), 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
